// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits behind a shared,
// 1-cycle registered hex decoder. Anodes light BLANK cycles after each digit change.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned SLOT   = 50000,
  parameter int unsigned BLANK  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [4*DIGITS-1:0]   iv_value,
  input  logic                  i_load,
  input  logic [DIGITS-1:0]     iv_blank_mask,
  input  logic                  i_lz_blank,
  output logic [3:0]            ov_digit,
  output logic [DIGITS-1:0]     ov_anode,
  output logic                  o_frame
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SLOT - 1);
  localparam logic [CntW-1:0] CntOn   = CntW'(BLANK);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StOn} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                run_q;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_mask_q, pend_mask_d;
  logic                pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0] shown_val_q, shown_val_d;
  logic [DIGITS-1:0]   shown_mask_q, shown_mask_d;
  logic [3:0]          digit_q, digit_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic                frame_q, frame_d;
  logic                enter;
  logic                frame_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      idx_q        <= '0;
      run_q        <= 1'b0;
      pend_val_q   <= '0;
      pend_mask_q  <= '0;
      pend_vld_q   <= 1'b0;
      shown_val_q  <= '0;
      shown_mask_q <= '0;
      digit_q      <= '0;
      anode_q      <= '1;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      run_q        <= 1'b1;
      pend_val_q   <= pend_val_d;
      pend_mask_q  <= pend_mask_d;
      pend_vld_q   <= pend_vld_d;
      shown_val_q  <= shown_val_d;
      shown_mask_q <= shown_mask_d;
      digit_q      <= digit_d;
      anode_q      <= anode_d;
      frame_q      <= frame_d;
    end
  end

  // The first cycle out of reset enters slot 0 so the scan always opens with a frame pulse.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    enter        = 1'b0;
    pend_val_d   = pend_val_q;
    pend_mask_d  = pend_mask_q;
    pend_vld_d   = pend_vld_q;
    shown_val_d  = shown_val_q;
    shown_mask_d = shown_mask_q;

    if (!run_q) begin
      cnt_d   = '0;
      idx_d   = '0;
      state_d = StBlank;
      enter   = 1'b1;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      state_d = StBlank;
      enter   = 1'b1;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_d == CntOn) ? StOn : state_q;
    end

    frame_start = enter && (idx_d == '0);

    if (frame_start && pend_vld_q) begin
      shown_val_d  = pend_val_q;
      shown_mask_d = pend_mask_q;
      pend_vld_d   = 1'b0;
    end
    // A load coinciding with the transfer is kept for the following frame.
    if (i_load) begin
      pend_val_d  = iv_value;
      pend_mask_d = iv_blank_mask;
      pend_vld_d  = 1'b1;
    end
  end

  logic [3:0] nib;
  logic       upper_nz;
  logic       mask_bit;
  logic       dark;

  always_comb begin
    nib      = '0;
    upper_nz = 1'b0;
    mask_bit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_d == IdxW'(i)) begin
        nib      = shown_val_d[4*i +: 4];
        mask_bit = shown_mask_d[i];
      end
      if ((IdxW'(i) >= idx_d) && (shown_val_d[4*i +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
    // Leading-zero blanking never darkens digit 0.
    dark = mask_bit || (i_lz_blank && (idx_d != '0) && !upper_nz);

    digit_d = enter ? nib : digit_q;
    anode_d = '1;
    if ((state_d == StOn) && !dark) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (idx_d == IdxW'(i)) anode_d[i] = 1'b0;
      end
    end
    frame_d = frame_start;
  end

  assign ov_digit = digit_q;
  assign ov_anode = anode_q;
  assign o_frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-slot digit/anode expectations are queued by the
// driver for each frame and compared by a monitor near the end of every slot.
module tb_seg7_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int FRAME  = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] iv_value;
  logic        i_load;
  logic [3:0]  iv_blank_mask;
  logic        i_lz_blank;
  logic [3:0]  ov_digit;
  logic [3:0]  ov_anode;
  logic        o_frame;

  seg7_scan_ctrl #(
    .DIGITS(DIGITS),
    .SLOT  (SLOT),
    .BLANK (BLANK)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .iv_value     (iv_value),
    .i_load       (i_load),
    .iv_blank_mask(iv_blank_mask),
    .i_lz_blank   (i_lz_blank),
    .ov_digit     (ov_digit),
    .ov_anode     (ov_anode),
    .o_frame      (o_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frame;
    int         slot;
    logic [3:0] digit;
    logic [3:0] anode;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   frame_cnt = 0;
  int   pos = 0;
  bit   synced = 0;
  bit   gap_ok = 0;

  // Reference model of the display registers.
  logic [15:0] m_shown = '0, m_pend = '0, m_lval = '0;
  logic [3:0]  m_smask = '0, m_pmask = '0;
  bit          m_vld = 0, m_late = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_anode(input logic [15:0] v, input logic [3:0] m,
                                           input bit lz, input int s);
    logic [3:0] one;
    bit dark;
    dark = m[s] || (lz && s > 0 && ((v >> (4 * s)) == 16'h0));
    one  = 4'b0001 << s;
    return dark ? 4'hF : ~one;
  endfunction

  always @(negedge clk) begin
    int c, s;
    check("anode_onehot", ($countones(~ov_anode) <= 1), 1);
    if (!rst_n) begin
      synced = 0;
      gap_ok = 0;
    end else if (o_frame) begin
      if (gap_ok) check("frame_period", pos + 1, FRAME);
      pos    = 0;
      synced = 1;
      gap_ok = 1;
      frame_cnt++;
    end else begin
      pos++;
    end
    if (synced && rst_n && pos < FRAME) begin
      c = pos % SLOT;
      s = pos / SLOT;
      if (c < BLANK) check("blank_window", ov_anode, 4'hF);
      if (c == SLOT - 1) begin
        while (sb_q.size() > 0 && (sb_q[0].frame < frame_cnt ||
               (sb_q[0].frame == frame_cnt && sb_q[0].slot < s))) begin
          check("sb_missed_frame", sb_q[0].frame, frame_cnt);
          void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].frame == frame_cnt && sb_q[0].slot == s) begin
          check($sformatf("digit_f%0d_s%0d", frame_cnt, s), ov_digit, sb_q[0].digit);
          check($sformatf("anode_f%0d_s%0d", frame_cnt, s), ov_anode, sb_q[0].anode);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_frame && n < 4 * FRAME);
    i_load = 1'b0;
    if (!o_frame) check("frame_timeout", o_frame, 1);
    #1;
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] m);
    iv_value      = v;
    iv_blank_mask = m;
    i_load        = 1'b1;
    m_pend        = v;
    m_pmask       = m;
    m_vld         = 1;
  endtask

  // One frame: apply the frame-start transfer to the model, queue expectations, then drive loads.
  task automatic step(input bit lz, input int nload, input logic [15:0] va, input logic [3:0] ma,
                      input logic [15:0] vb, input logic [3:0] mb, input bit late,
                      input logic [15:0] vl);
    wait_frame();
    if (m_vld) begin
      m_shown = m_pend;
      m_smask = m_pmask;
      m_vld   = 0;
    end
    if (m_late) begin
      m_pend  = m_lval;
      m_pmask = '0;
      m_vld   = 1;
      m_late  = 0;
    end
    i_lz_blank = lz;
    for (int s = 0; s < DIGITS; s++) begin
      sb_q.push_back('{frame: frame_cnt, slot: s, digit: m_shown[4*s +: 4],
                       anode: exp_anode(m_shown, m_smask, lz, s)});
    end
    for (int p = 1; p < FRAME; p++) begin
      @(negedge clk);
      i_load = 1'b0;
      if (nload >= 1 && p == 5)  drive_load(va, ma);
      if (nload >= 2 && p == 20) drive_load(vb, mb);
      if (late && p == FRAME - 1) begin
        iv_value      = vl;
        iv_blank_mask = '0;
        i_load        = 1'b1;
        m_lval        = vl;
        m_late        = 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    iv_value      = '0;
    i_load        = 1'b0;
    iv_blank_mask = '0;
    i_lz_blank    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_anode", ov_anode, 4'hF);
    check("rst_digit", ov_digit, 4'h0);
    check("rst_frame", o_frame, 0);
    rst_n = 1'b1;

    step(0, 1, 16'h1234, 4'h0, 16'h0, 4'h0, 0, 16'h0);     // shows reset value 0000
    step(0, 2, 16'hABCD, 4'h0, 16'h00F0, 4'h0, 0, 16'h0);  // shows 1234, last load wins
    step(0, 1, 16'h0050, 4'h0, 16'h0, 4'h0, 0, 16'h0);     // shows 00F0
    step(1, 1, 16'h0000, 4'h0, 16'h0, 4'h0, 0, 16'h0);     // shows 0050 with LZ blank
    step(1, 1, 16'h8888, 4'h5, 16'h0, 4'h0, 0, 16'h0);     // shows 0000 with LZ blank
    step(0, 0, 16'h0, 4'h0, 16'h0, 4'h0, 1, 16'h4321);     // shows 8888 mask 0101
    step(0, 0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 16'h0);        // late load still pending
    step(0, 0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 16'h0);        // shows 4321

    // Reset in the ON phase of digit 2, with a load pending that must be discarded.
    wait_frame();
    for (int p = 1; p <= 2 * SLOT + 5; p++) begin
      @(negedge clk);
      i_load = 1'b0;
      if (p == 3) begin
        iv_value = 16'h9999;
        i_load   = 1'b1;
      end
    end
    check("pre_rst_anode", ov_anode, 4'b1011);
    check("pre_rst_digit", ov_digit, 4'h3);
    rst_n = 1'b0;
    #1;
    check("async_rst_anode", ov_anode, 4'hF);
    repeat (2) @(negedge clk);
    check("mid_rst_digit", ov_digit, 4'h0);
    check("mid_rst_frame", o_frame, 0);
    rst_n   = 1'b1;
    m_shown = '0;
    m_smask = '0;
    m_vld   = 0;
    m_late  = 0;
    @(negedge clk);
    check("post_rst_frame", o_frame, 1);
    check("post_rst_digit", ov_digit, 4'h0);
    step(0, 0, 16'h0, 4'h0, 16'h0, 4'h0, 0, 16'h0);        // pending data lost: 0000

    repeat (2) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
